// File: rtl/axis_packet_crossbar.sv
// N_INPUTS x N_OUTPUTS AXI-Stream crossbar. Each output follows its own select,
// but it only switches at packet boundaries, so packets are never split or interleaved.
module axis_packet_crossbar #(
  parameter int WIDTH     = 32,
  parameter int N_INPUTS  = 3,
  parameter int N_OUTPUTS = 2,
  parameter int SEL_WIDTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_OUTPUTS*SEL_WIDTH-1:0] sel,
  input  logic [N_INPUTS*WIDTH-1:0]      s_tdata,
  input  logic [N_INPUTS-1:0]            s_tvalid,
  input  logic [N_INPUTS-1:0]            s_tlast,
  output logic [N_INPUTS-1:0]            s_tready,
  output logic [N_OUTPUTS*WIDTH-1:0]     m_tdata,
  output logic [N_OUTPUTS-1:0]           m_tvalid,
  output logic [N_OUTPUTS-1:0]           m_tlast,
  input  logic [N_OUTPUTS-1:0]           m_tready,
  output logic [N_OUTPUTS-1:0]           busy
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t               state_q  [N_OUTPUTS];
  logic [SEL_WIDTH-1:0] selReg_q [N_OUTPUTS];
  logic [N_OUTPUTS-1:0] mValid_q;
  logic [N_OUTPUTS-1:0] mLast_q;
  logic [WIDTH-1:0]     mData_q  [N_OUTPUTS];
  // Held low for the first cycle after reset so nothing is accepted with stale selects.
  logic                 active_q;

  logic [N_OUTPUTS-1:0] inRange;
  logic [N_OUTPUTS-1:0] blocked;
  logic [N_OUTPUTS-1:0] own;
  logic [N_OUTPUTS-1:0] inValid;
  logic [N_OUTPUTS-1:0] inLast;
  logic [N_OUTPUTS-1:0] xfer;
  logic [WIDTH-1:0]     inData   [N_OUTPUTS];

  // Ownership: a LOCKED output keeps its input; an IDLE one yields to any LOCKED
  // output or lower-index IDLE output on the same input.
  always_comb begin
    inRange = '0;
    blocked = '0;
    own     = '0;
    for (int j = 0; j < N_OUTPUTS; j++) begin
      inRange[j] = int'(selReg_q[j]) < N_INPUTS;
    end
    for (int j = 0; j < N_OUTPUTS; j++) begin
      for (int k = 0; k < N_OUTPUTS; k++) begin
        if (k != j && state_q[k] == LOCKED && selReg_q[k] == selReg_q[j]) begin
          blocked[j] = 1'b1;
        end
        if (k < j && state_q[k] == IDLE && inRange[k] && selReg_q[k] == selReg_q[j]) begin
          blocked[j] = 1'b1;
        end
      end
      if (active_q && inRange[j]) begin
        own[j] = (state_q[j] == LOCKED) ? 1'b1 : ~blocked[j];
      end
    end
  end

  always_comb begin
    s_tready = '0;
    inValid  = '0;
    inLast   = '0;
    xfer     = '0;
    for (int j = 0; j < N_OUTPUTS; j++) begin
      inData[j] = '0;
      for (int i = 0; i < N_INPUTS; i++) begin
        if (own[j] && int'(selReg_q[j]) == i) begin
          s_tready[i] = s_tready[i] | m_tready[j] | ~mValid_q[j];
          inValid[j]  = s_tvalid[i];
          inLast[j]   = s_tlast[i];
          inData[j]   = s_tdata[i*WIDTH +: WIDTH];
        end
      end
      xfer[j] = own[j] & inValid[j] & (m_tready[j] | ~mValid_q[j]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      mValid_q <= '0;
      mLast_q  <= '0;
      for (int j = 0; j < N_OUTPUTS; j++) begin
        state_q[j]  <= IDLE;
        selReg_q[j] <= '0;
        mData_q[j]  <= '0;
      end
    end else begin
      active_q <= 1'b1;
      for (int j = 0; j < N_OUTPUTS; j++) begin
        case (state_q[j])
          IDLE: begin
            selReg_q[j] <= sel[j*SEL_WIDTH +: SEL_WIDTH];
            if (xfer[j] && !inLast[j]) state_q[j] <= LOCKED;
          end
          LOCKED: begin
            if (xfer[j] && inLast[j]) state_q[j] <= IDLE;
          end
          default: state_q[j] <= IDLE;
        endcase
        if (xfer[j]) begin
          mData_q[j]  <= inData[j];
          mLast_q[j]  <= inLast[j];
          mValid_q[j] <= 1'b1;
        end else if (m_tready[j]) begin
          mValid_q[j] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    for (int j = 0; j < N_OUTPUTS; j++) begin
      m_tdata[j*WIDTH +: WIDTH] = mData_q[j];
      busy[j]                   = (state_q[j] == LOCKED);
    end
  end

  assign m_tvalid = mValid_q;
  assign m_tlast  = mLast_q;

endmodule

// File: tb/tb_axis_packet_crossbar.sv
// Directed bench for axis_packet_crossbar (3 inputs, 2 outputs): reset, passthrough,
// packet-safe switching, backpressure, contention, out-of-range select and mid-packet reset.
module tb_axis_packet_crossbar;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sel0, sel1;
  logic [31:0] d [3];
  logic [2:0]  sValid, sLast, sReady;
  logic [63:0] mData;
  logic [1:0]  mValid, mLast, mReady, busy;

  int testCount = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  axis_packet_crossbar #(
    .WIDTH(32), .N_INPUTS(3), .N_OUTPUTS(2), .SEL_WIDTH(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sel      ({sel1, sel0}),
    .s_tdata  ({d[2], d[1], d[0]}),
    .s_tvalid (sValid),
    .s_tlast  (sLast),
    .s_tready (sReady),
    .m_tdata  (mData),
    .m_tvalid (mValid),
    .m_tlast  (mLast),
    .m_tready (mReady),
    .busy     (busy)
  );

  // Every comparison goes through here so the counters stay honest.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance one clock and land on the falling edge, where inputs change and outputs are sampled.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [2:0] valid, input logic [2:0] last,
                               input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
    sValid = valid;
    sLast  = last;
    d[0]   = d0;
    d[1]   = d1;
    d[2]   = d2;
  endtask

  // Outputs 0 state check: data, valid, last, busy.
  task automatic checkOut0(input string tag, input logic [31:0] data, input logic valid,
                           input logic last, input logic bsy);
    checkOutput({tag, " m0 data"}, mData[31:0], data);
    checkOutput({tag, " m0 valid"}, {31'd0, mValid[0]}, {31'd0, valid});
    checkOutput({tag, " m0 last"}, {31'd0, mLast[0]}, {31'd0, last});
    checkOutput({tag, " busy0"}, {31'd0, busy[0]}, {31'd0, bsy});
  endtask

  task automatic checkOut1(input string tag, input logic [31:0] data, input logic valid,
                           input logic last, input logic bsy);
    checkOutput({tag, " m1 data"}, mData[63:32], data);
    checkOutput({tag, " m1 valid"}, {31'd0, mValid[1]}, {31'd0, valid});
    checkOutput({tag, " m1 last"}, {31'd0, mLast[1]}, {31'd0, last});
    checkOutput({tag, " busy1"}, {31'd0, busy[1]}, {31'd0, bsy});
  endtask

  task automatic checkReady(input string tag, input logic [2:0] expected);
    #1;
    checkOutput({tag, " s_tready"}, {29'd0, sReady}, {29'd0, expected});
  endtask

  initial begin
    // Reset held two clocks with every input valid.
    rst    = 1'b1;
    sel0   = 2'd3;
    sel1   = 2'd3;
    mReady = 2'b11;
    applyStimulus(3'b111, 3'b000, 32'h11, 32'h22, 32'h33);
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      checkOutput("reset mvalid", {30'd0, mValid}, 32'd0);
      checkOutput("reset busy", {30'd0, busy}, 32'd0);
      checkReady("reset", 3'b000);
      checkOutput("reset mdata", mData[31:0], 32'd0);
      if (c == 0) tick();
    end
    rst = 1'b0;
    checkReady("post-release", 3'b000);
    tick();
    checkOutput("post-release mvalid", {30'd0, mValid}, 32'd0);
    checkOutput("post-release busy", {30'd0, busy}, 32'd0);
    checkReady("sel out of range", 3'b000);

    // Passthrough from input 1 to output 0.
    sel0 = 2'd1;
    applyStimulus(3'b000, 3'b000, 32'h0, 32'h0, 32'h0);
    tick();
    checkReady("pass idle", 3'b010);
    applyStimulus(3'b010, 3'b000, 32'h0, 32'hA0, 32'h0);
    tick();
    checkOut0("pass A0", 32'hA0, 1'b1, 1'b0, 1'b1);
    applyStimulus(3'b010, 3'b000, 32'h0, 32'hA1, 32'h0);
    tick();
    checkOut0("pass A1", 32'hA1, 1'b1, 1'b0, 1'b1);

    // Select moves to input 2 mid-packet; input 2 is waiting with a single-beat packet.
    sel0 = 2'd2;
    applyStimulus(3'b110, 3'b100, 32'h0, 32'hA2, 32'hC0);
    checkReady("switch locked", 3'b010);
    tick();
    checkOut0("switch A2", 32'hA2, 1'b1, 1'b0, 1'b1);

    // Backpressure for three clocks while A3 waits.
    applyStimulus(3'b110, 3'b110, 32'h0, 32'hA3, 32'hC0);
    mReady[0] = 1'b0;
    checkReady("bp full", 3'b000);
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOut0("bp hold", 32'hA2, 1'b1, 1'b0, 1'b1);
      checkReady("bp stall", 3'b000);
    end
    mReady[0] = 1'b1;
    checkReady("bp release", 3'b010);
    tick();
    checkOut0("switch A3", 32'hA3, 1'b1, 1'b1, 1'b0);
    applyStimulus(3'b100, 3'b100, 32'h0, 32'h0, 32'hC0);
    tick();
    checkOutput("switch gap mvalid0", {31'd0, mValid[0]}, 32'd0);
    checkReady("switch new owner", 3'b100);
    tick();
    checkOut0("switch C0", 32'hC0, 1'b1, 1'b1, 1'b0);
    applyStimulus(3'b000, 3'b000, 32'h0, 32'h0, 32'h0);
    tick();
    checkOutput("drain mvalid0", {31'd0, mValid[0]}, 32'd0);

    // Contention: both outputs on input 0, lower index wins.
    sel0 = 2'd0;
    sel1 = 2'd0;
    tick();
    checkReady("cont idle", 3'b001);
    applyStimulus(3'b001, 3'b001, 32'hB0, 32'h0, 32'h0);
    tick();
    checkOut0("cont B0", 32'hB0, 1'b1, 1'b1, 1'b0);
    checkOutput("cont m1 idle", {31'd0, mValid[1]}, 32'd0);

    // Lock output 1 on input 0, then bring output 0 back as a requester.
    sel0 = 2'd3;
    applyStimulus(3'b000, 3'b000, 32'h0, 32'h0, 32'h0);
    tick();
    checkOutput("cont drain0", {31'd0, mValid[0]}, 32'd0);
    applyStimulus(3'b001, 3'b000, 32'hD0, 32'h0, 32'h0);
    tick();
    checkOut1("cont D0", 32'hD0, 1'b1, 1'b0, 1'b1);
    sel0 = 2'd0;
    applyStimulus(3'b001, 3'b000, 32'hD1, 32'h0, 32'h0);
    tick();
    checkOut1("cont D1", 32'hD1, 1'b1, 1'b0, 1'b1);
    checkOutput("cont m0 waits", {31'd0, mValid[0]}, 32'd0);
    applyStimulus(3'b001, 3'b001, 32'hD2, 32'h0, 32'h0);
    checkReady("cont locked owner", 3'b001);
    tick();
    checkOut1("cont D2", 32'hD2, 1'b1, 1'b1, 1'b0);
    checkOutput("cont m0 still waits", {31'd0, mValid[0]}, 32'd0);
    applyStimulus(3'b001, 3'b001, 32'hE0, 32'h0, 32'h0);
    tick();
    checkOut0("cont E0", 32'hE0, 1'b1, 1'b1, 1'b0);
    checkOutput("cont m1 drained", {31'd0, mValid[1]}, 32'd0);

    // Output 0 out of range while output 1 carries a packet that reset cuts off.
    sel0 = 2'd3;
    sel1 = 2'd1;
    applyStimulus(3'b000, 3'b000, 32'h0, 32'h0, 32'h0);
    tick();
    checkOutput("oor mvalid0", {31'd0, mValid[0]}, 32'd0);
    applyStimulus(3'b111, 3'b000, 32'h1, 32'hF0, 32'h2);
    checkReady("oor ready", 3'b010);
    tick();
    checkOut1("oor F0", 32'hF0, 1'b1, 1'b0, 1'b1);
    checkOutput("oor m0 idle", {31'd0, mValid[0]}, 32'd0);
    applyStimulus(3'b111, 3'b000, 32'h1, 32'hF1, 32'h2);
    rst = 1'b1;
    tick();
    checkOutput("midrst mvalid", {30'd0, mValid}, 32'd0);
    checkOutput("midrst mlast", {30'd0, mLast}, 32'd0);
    checkOutput("midrst busy", {30'd0, busy}, 32'd0);
    checkOutput("midrst m1 data", mData[63:32], 32'd0);
    checkReady("midrst", 3'b000);
    rst = 1'b0;
    applyStimulus(3'b000, 3'b000, 32'h0, 32'h0, 32'h0);
    tick();

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
